memory_arbiter: RTL



---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/arb_select.sv | 43 ++++
 rtl/memory_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state and the bus arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    IDLE,
    SERVE
  } arbstate_t;

endpackage

// File: rtl/arb_select.sv
// Combinational requester picker: D before I within a core, core rr checked before core rr+1.
module arb_select #(
  parameter int unsigned CPUS = 2
) (
  input  logic [CPUS-1:0] D,
  input  logic [CPUS-1:0] I,
  input  logic [CPUS-1:0] wen,
  input  logic            rr,
  output logic            valid,
  output logic            core,
  output logic            isData,
  output logic            isWrite
);

  // Core examined at round-robin offset k from the pointer.
  function automatic logic cidx(input logic r, input int k);
    if (CPUS == 1) return 1'b0;
    return r ^ k[0];
  endfunction

  // Walk from the lowest priority upwards so the highest-priority hit is written last.
  always_comb begin
    valid   = 1'b0;
    core    = 1'b0;
    isData  = 1'b0;
    isWrite = 1'b0;
    for (int k = int'(CPUS) - 1; k >= 0; k--) begin
      if (I[cidx(rr, k)]) begin
        valid   = 1'b1;
        core    = cidx(rr, k);
        isData  = 1'b0;
        isWrite = 1'b0;
      end
      if (D[cidx(rr, k)]) begin
        valid   = 1'b1;
        core    = cidx(rr, k);
        isData  = 1'b1;
        isWrite = wen[cidx(rr, k)];
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shared-RAM arbiter for per-core icache/dcache: one IDLE arbitration cycle, then SERVE
// until the RAM reports ACCESS or the granted requester withdraws.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic      [CPUS-1:0] iREN,
  input  logic      [CPUS-1:0] dREN,
  input  logic      [CPUS-1:0] dWEN,
  input  word_t     [CPUS-1:0] iaddr,
  input  word_t     [CPUS-1:0] daddr,
  input  word_t     [CPUS-1:0] dstore,
  output logic      [CPUS-1:0] iwait,
  output logic      [CPUS-1:0] dwait,
  output word_t     [CPUS-1:0] iload,
  output word_t     [CPUS-1:0] dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate
);

  arbstate_t state_q, state_d;
  logic      rr_q, rr_d;
  logic      core_q, core_d;
  logic      data_q, data_d;
  logic      write_q, write_d;

  logic [CPUS-1:0] dreq;
  logic            sel_valid, sel_core, sel_data, sel_write;
  logic            live_req;

  assign dreq = dREN | dWEN;

  arb_select #(
    .CPUS(CPUS)
  ) u_select (
    .D      (dreq),
    .I      (iREN),
    .wen    (dWEN),
    .rr     (rr_q),
    .valid  (sel_valid),
    .core   (sel_core),
    .isData (sel_data),
    .isWrite(sel_write)
  );

  // Request of the port currently holding the grant, sampled live.
  assign live_req = data_q ? dreq[core_q] : iREN[core_q];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      core_q  <= 1'b0;
      data_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      core_q  <= core_d;
      data_q  <= data_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    core_d  = core_q;
    data_d  = data_q;
    write_d = write_q;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = SERVE;
          core_d  = sel_core;
          data_d  = sel_data;
          write_d = sel_write;
        end
      end
      SERVE: begin
        if (ramstate == ACCESS) begin
          state_d = IDLE;
          rr_d    = (CPUS == 2) ? ~rr_q : 1'b0;
        end else if (!live_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (state_q == SERVE) begin
      ramREN   = ~write_q;
      ramWEN   = write_q;
      ramaddr  = data_q ? daddr[core_q] : iaddr[core_q];
      ramstore = data_q ? dstore[core_q] : '0;
      if (ramstate == ACCESS) begin
        if (data_q) dwait[core_q] = 1'b0;
        else        iwait[core_q] = 1'b0;
      end
    end
  end

  always_comb begin
    iload = '0;
    dload = '0;
    for (int c = 0; c < int'(CPUS); c++) begin
      iload[c] = ramload;
      dload[c] = ramload;
    end
  end

endmodule
